// File: rtl/mpc_wb_router_if.sv
// Host-side and macro-side Wishbone bundle for the user-macro router.
interface mpc_wb_router_if #(
  parameter int N_MACROS = 4
);
  logic                     wbs_stb_i;
  logic                     wbs_cyc_i;
  logic                     wbs_we_i;
  logic [3:0]               wbs_sel_i;
  logic [31:0]              wbs_dat_i;
  logic [31:0]              wbs_adr_i;
  logic                     wbs_ack_o;
  logic [31:0]              wbs_dat_o;

  logic [N_MACROS-1:0]      m_cyc_o;
  logic [N_MACROS-1:0]      m_stb_o;
  logic                     m_we_o;
  logic [3:0]               m_sel_o;
  logic [31:0]              m_adr_o;
  logic [31:0]              m_dat_o;
  logic [N_MACROS-1:0]      m_ack_i;
  logic [N_MACROS-1:0][31:0] m_dat_i;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  m_ack_i, m_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output m_ack_i, m_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o
  );
endinterface

// File: rtl/mpc_wb_router.sv
// Routes host Wishbone accesses to one of N_MACROS user macros by address field,
// with local CFG/STATUS registers, an unmapped-region responder and an ack timeout.
module mpc_wb_port #(
  parameter logic [3:0] K = 4'd0
) (
  input  logic        fwd,
  input  logic [3:0]  idx,
  input  logic        ack,
  input  logic [31:0] dat,
  output logic        stb,
  output logic        hit,
  output logic [31:0] dat_g
);
  assign stb   = fwd && (idx == K);
  assign hit   = stb && ack;
  assign dat_g = stb ? dat : 32'd0;
endmodule

module mpc_wb_router #(
  parameter int N_MACROS = 4,
  parameter int TIMEOUT  = 255,
  parameter int SEL_LSB  = 20
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  mpc_wb_router_if.slave      bus,
  output logic [3:0]          configuration,
  output logic                timeout_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, ACK = 2'd2} state_t;

  localparam logic [3:0]  NM     = 4'(N_MACROS);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);

  state_t                     state, nxt;
  logic [3:0]                 idx_q, last_to;
  logic [15:0]                wcnt;
  logic [N_MACROS-1:0]        stb, hit;
  logic [N_MACROS-1:0][31:0]  dat_g;
  logic [31:0]                sel_dat, loc_rd;
  logic                       ack_hit, to_hit, fwd, req, is_loc, is_map;
  logic [3:0]                 idx;
  logic [1:0]                 off;

  assign req    = bus.wbs_cyc_i && bus.wbs_stb_i;
  assign idx    = bus.wbs_adr_i[SEL_LSB+3:SEL_LSB];
  assign off    = bus.wbs_adr_i[3:2];
  assign is_loc = (idx == 4'hF);
  assign is_map = !is_loc && (idx < NM);

  for (genvar k = 0; k < N_MACROS; k++) begin : g_port
    mpc_wb_port #(.K(4'(k))) u_port (
      .fwd   (fwd),
      .idx   (idx_q),
      .ack   (bus.m_ack_i[k]),
      .dat   (bus.m_dat_i[k]),
      .stb   (stb[k]),
      .hit   (hit[k]),
      .dat_g (dat_g[k])
    );
  end

  // Only the selected port can contribute, so an OR-reduce is the slice mux.
  always_comb begin
    sel_dat = 32'd0;
    ack_hit = 1'b0;
    for (int k = 0; k < N_MACROS; k++) begin
      sel_dat = sel_dat | dat_g[k];
      ack_hit = ack_hit | hit[k];
    end
  end

  // Ack beats timeout when both land in the same cycle.
  assign to_hit = fwd && !ack_hit && (wcnt == TO_LIM);

  always_comb begin
    case (off)
      2'd0:    loc_rd = {28'd0, configuration};
      2'd1:    loc_rd = {20'd0, last_to, 7'd0, timeout_err};
      default: loc_rd = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req) nxt = is_map ? FWD : ACK;
      FWD: begin
        if (!bus.wbs_cyc_i)         nxt = IDLE;
        else if (ack_hit || to_hit) nxt = ACK;
      end
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    fwd           = (state == FWD);
    bus.wbs_ack_o = (state == ACK);
    bus.m_stb_o   = stb;
    bus.m_cyc_o   = stb;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx_q         <= 4'd0;
      wcnt          <= 16'd0;
      last_to       <= 4'd0;
      configuration <= 4'd0;
      timeout_err   <= 1'b0;
      bus.wbs_dat_o <= 32'd0;
      bus.m_adr_o   <= 32'd0;
      bus.m_dat_o   <= 32'd0;
      bus.m_we_o    <= 1'b0;
      bus.m_sel_o   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (is_map) begin
            idx_q       <= idx;
            wcnt        <= 16'd0;
            bus.m_adr_o <= bus.wbs_adr_i;
            bus.m_dat_o <= bus.wbs_dat_i;
            bus.m_we_o  <= bus.wbs_we_i;
            bus.m_sel_o <= bus.wbs_sel_i;
          end else if (is_loc) begin
            if (bus.wbs_we_i) begin
              if (off == 2'd0 && bus.wbs_sel_i[0]) configuration <= bus.wbs_dat_i[3:0];
              if (off == 2'd1 && bus.wbs_sel_i[0] && bus.wbs_dat_i[0]) timeout_err <= 1'b0;
            end else begin
              bus.wbs_dat_o <= loc_rd;
            end
          end else if (!bus.wbs_we_i) begin
            bus.wbs_dat_o <= 32'hBADA_DD00;
          end
        end
        FWD: if (bus.wbs_cyc_i) begin
          if (ack_hit) begin
            bus.wbs_dat_o <= sel_dat;
          end else if (to_hit) begin
            bus.wbs_dat_o <= 32'hFFFF_FFFF;
            timeout_err   <= 1'b1;
            last_to       <= idx_q;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mpc_wb_router.sv
// Bench for mpc_wb_router: three configurations (N_MACROS 4/2/8, TIMEOUT 8), directed
// table, multi-cycle abort/reset sequences, routing sweep and randomized traffic.
module tb_mpc_wb_router;
  localparam int TO = 8;

  logic        clk, rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  int          cur;
  int          ack_dly;
  bit          ovr_en;
  logic [31:0] ovr_dat;

  logic        ack_g   [3];
  logic [31:0] dat_g   [3];
  logic [7:0]  stb_g   [3];
  logic [7:0]  cyc_g   [3];
  logic [31:0] madr_g  [3];
  logic [31:0] mdat_g  [3];
  logic        mwe_g   [3];
  logic [3:0]  msel_g  [3];
  logic [3:0]  cfg_g   [3];
  logic        terr_g  [3];

  int nvec = 0, nerr = 0, cycbad = 0;
  logic [3:0] mcfg [3];
  logic       mterr[3];
  logic [3:0] mlto [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfgs
    localparam int N = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    mpc_wb_router_if #(.N_MACROS(N)) bif ();
    logic [7:0]   rcnt;
    logic [N-1:0] noise;

    mpc_wb_router #(.N_MACROS(N), .TIMEOUT(TO), .SEL_LSB(20)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .bus           (bif.slave),
      .configuration (cfg_g[g]),
      .timeout_err   (terr_g[g])
    );

    assign bif.wbs_cyc_i = cyc && (cur == g);
    assign bif.wbs_stb_i = stb && (cur == g);
    assign bif.wbs_we_i  = we;
    assign bif.wbs_sel_i = sel;
    assign bif.wbs_adr_i = adr;
    assign bif.wbs_dat_i = wdat;

    // Selected macro acks after ack_dly strobe cycles; the others emit random ack noise.
    always @(posedge clk) begin
      rcnt  <= (bif.m_stb_o != '0) ? rcnt + 8'd1 : 8'd0;
      noise <= N'($urandom);
    end
    always_comb begin
      bif.m_ack_i = '0;
      bif.m_dat_i = '0;
      for (int k = 0; k < N; k++) begin
        bif.m_ack_i[k] = (bif.m_stb_o[k] && rcnt == 8'(ack_dly)) || (noise[k] && !bif.m_stb_o[k]);
        bif.m_dat_i[k] = ovr_en ? ovr_dat : {4'hC, 4'(k), 8'(g), bif.m_adr_o[15:0]};
      end
    end

    assign ack_g[g]  = bif.wbs_ack_o;
    assign dat_g[g]  = bif.wbs_dat_o;
    assign stb_g[g]  = 8'(bif.m_stb_o);
    assign cyc_g[g]  = 8'(bif.m_cyc_o);
    assign madr_g[g] = bif.m_adr_o;
    assign mdat_g[g] = bif.m_dat_o;
    assign mwe_g[g]  = bif.m_we_o;
    assign msel_g[g] = bif.m_sel_o;
  end

  function automatic int ncfg(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 2 : 8);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      mcfg[g] = 4'd0; mterr[g] = 1'b0; mlto[g] = 4'd0;
    end
  endtask

  // Transaction-level reference: latency, read data and the strobe pattern of one access.
  task automatic model(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int dly,
                       output int lat, output logic [31:0] ed, output logic [7:0] es);
    logic [3:0] ix;
    logic [1:0] of;
    ix = a[23:20]; of = a[3:2];
    lat = 1; ed = 32'd0; es = 8'd0;
    if (ix == 4'hF) begin
      if (w) begin
        if (of == 2'd0 && s[0]) mcfg[g] = d[3:0];
        if (of == 2'd1 && s[0] && d[0]) mterr[g] = 1'b0;
      end else if (of == 2'd0) ed = {28'd0, mcfg[g]};
      else if (of == 2'd1) ed = {20'd0, mlto[g], 7'd0, mterr[g]};
    end else if (int'(ix) < ncfg(g)) begin
      es = 8'd1 << ix;
      if (dly < TO) begin
        lat = dly + 2;
        ed  = {4'hC, ix, 8'(g), a[15:0]};
      end else begin
        lat = TO + 1;
        ed  = 32'hFFFF_FFFF;
        mterr[g] = 1'b1;
        mlto[g]  = ix;
      end
    end else begin
      ed = 32'hBADA_DD00;
    end
  endtask

  task automatic run(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat, output logic [31:0] rd,
                     output logic [7:0] stbs, output logic [31:0] sa, output logic [31:0] sd,
                     output logic swe, output logic [3:0] ssel);
    @(negedge clk);
    cur = g; cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0; stbs = 8'd0; sa = 32'd0; sd = 32'd0; swe = 1'b0; ssel = 4'd0;
    forever begin
      @(negedge clk);
      lat++;
      stbs |= stb_g[g];
      if (cyc_g[g] != stb_g[g]) cycbad++;
      if (stb_g[g] != 8'd0) begin
        sa = madr_g[g]; sd = mdat_g[g]; swe = mwe_g[g]; ssel = msel_g[g];
      end
      if (ack_g[g]) break;
      if (lat > 40) begin
        chk("ack_wait_bound", 32'd1, 32'd0);
        break;
      end
    end
    rd = dat_g[g];
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack_g[g]), 32'd0);
  endtask

  task automatic txn(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int dly);
    int lat, lat_e;
    logic [31:0] rd, ed, sa, sd;
    logic [7:0] stbs, es;
    logic swe;
    logic [3:0] ssel;
    model(g, w, a, d, s, dly, lat_e, ed, es);
    ack_dly = dly;
    run(g, w, a, d, s, lat, rd, stbs, sa, sd, swe, ssel);
    chk("latency", 32'(lat), 32'(lat_e));
    chk("stb_pattern", 32'(stbs), 32'(es));
    if (!w) chk("rdata", rd, ed);
    if (es != 8'd0) begin
      chk("m_adr", sa, a);
      chk("m_dat", sd, d);
      chk("m_we", 32'(swe), 32'(w));
      chk("m_sel", 32'(ssel), 32'(s));
    end
    chk("configuration", 32'(cfg_g[g]), 32'(mcfg[g]));
    chk("timeout_err", 32'(terr_g[g]), 32'(mterr[g]));
  endtask

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk({tag, "_ack"}, 32'(ack_g[g]), 32'd0);
      chk({tag, "_dat"}, dat_g[g], 32'd0);
      chk({tag, "_stb"}, 32'(stb_g[g] | cyc_g[g]), 32'd0);
      chk({tag, "_madr"}, madr_g[g] | mdat_g[g], 32'd0);
      chk({tag, "_mwe_sel"}, {27'd0, mwe_g[g], msel_g[g]}, 32'd0);
      chk({tag, "_cfg"}, 32'(cfg_g[g]), 32'd0);
      chk({tag, "_terr"}, 32'(terr_g[g]), 32'd0);
    end
  endtask

  typedef struct {
    bit          w;
    logic [3:0]  idx;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [3:0]  s;
    int          dly;
    logic [31:0] mdat;
    int          lat;
    logic [31:0] edat;
    logic [7:0]  estb;
    logic [3:0]  ecfg;
    bit          eterr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int lat, dl, ml;
    logic [31:0] a, rd, sa, sd, ed;
    logic [7:0] stbs, es;
    logic swe;
    logic [3:0] ssel, ix;

    //           w  idx   off  wdat          sel   dly  mdat          lat edat          estb  cfg   terr
    tbl[0]  = '{1, 4'hF, 2'd0, 32'h0000_0005, 4'hF, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};
    tbl[1]  = '{0, 4'hF, 2'd0, 32'h0,         4'hF, 0,   32'h0,         1, 32'h0000_0005, 8'h0, 4'h5, 0};
    tbl[2]  = '{1, 4'hF, 2'd0, 32'h0000_000A, 4'hE, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};
    tbl[3]  = '{0, 4'h2, 2'd0, 32'h0,         4'hF, 3,   32'h1234_5678, 5, 32'h1234_5678, 8'h4, 4'h5, 0};
    tbl[4]  = '{0, 4'h1, 2'd0, 32'h0,         4'hF, 255, 32'h5555_5555, 9, 32'hFFFF_FFFF, 8'h2, 4'h5, 1};
    tbl[5]  = '{0, 4'hF, 2'd1, 32'h0,         4'hF, 0,   32'h0,         1, 32'h0000_0101, 8'h0, 4'h5, 1};
    tbl[6]  = '{1, 4'hF, 2'd1, 32'h0000_0001, 4'h1, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};
    tbl[7]  = '{0, 4'hF, 2'd1, 32'h0,         4'hF, 0,   32'h0,         1, 32'h0000_0100, 8'h0, 4'h5, 0};
    tbl[8]  = '{0, 4'h6, 2'd0, 32'h0,         4'hF, 0,   32'h0,         1, 32'hBADA_DD00, 8'h0, 4'h5, 0};
    tbl[9]  = '{1, 4'h6, 2'd0, 32'h0000_0001, 4'hF, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};
    tbl[10] = '{0, 4'hF, 2'd2, 32'h0,         4'hF, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};
    tbl[11] = '{0, 4'h3, 2'd0, 32'h0,         4'hF, 7,   32'hDEAD_BEEF, 9, 32'hDEAD_BEEF, 8'h8, 4'h5, 0};
    tbl[12] = '{1, 4'h0, 2'd3, 32'hCAFE_0001, 4'h3, 0,   32'h0BAD_F00D, 2, 32'h0,         8'h1, 4'h5, 0};
    tbl[13] = '{0, 4'hF, 2'd3, 32'h0,         4'hF, 0,   32'h0,         1, 32'h0,         8'h0, 4'h5, 0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = 32'd0; wdat = 32'd0;
    cur = 0; ack_dly = 255; ovr_en = 1'b0; ovr_dat = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      a = 32'd0; a[23:20] = tbl[i].idx; a[3:2] = tbl[i].off; a[15:8] = 8'(i);
      ovr_en = 1'b1; ovr_dat = tbl[i].mdat; ack_dly = tbl[i].dly;
      model(0, tbl[i].w, a, tbl[i].wd, tbl[i].s, tbl[i].dly, ml, ed, es);
      run(0, tbl[i].w, a, tbl[i].wd, tbl[i].s, lat, rd, stbs, sa, sd, swe, ssel);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_stb", i), 32'(stbs), 32'(tbl[i].estb));
      if (!tbl[i].w) chk($sformatf("tbl%0d_dat", i), rd, tbl[i].edat);
      chk($sformatf("tbl%0d_cfg", i), 32'(cfg_g[0]), 32'(tbl[i].ecfg));
      chk($sformatf("tbl%0d_terr", i), 32'(terr_g[0]), 32'(tbl[i].eterr));
    end
    ovr_en = 1'b0;

    // Host abandons the cycle in the second forwarding cycle.
    ack_dly = 255;
    @(negedge clk);
    cur = 0; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0010_0040;
    @(negedge clk);
    @(negedge clk);
    chk("abort_stb_before", 32'(stb_g[0]), 32'h2);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_stb_after", 32'(stb_g[0]), 32'h0);
    dl = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_g[0]) dl++;
    end
    chk("abort_no_ack", 32'(dl), 32'd0);
    chk("abort_no_err", 32'(terr_g[0]), 32'(mterr[0]));

    // Reset pulsed while a macro is being strobed.
    @(negedge clk);
    cur = 0; cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 32'h1357_9BDF; adr = 32'h0020_0010;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_stb_before", 32'(stb_g[0]), 32'h4);
    #2 rst = 1'b1;
    #1 chk_zero("rstmid");
    model_reset();
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dl = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_g[0] || stb_g[0] != 8'd0) dl++;
    end
    chk("rstmid_quiet", 32'(dl), 32'd0);

    // Every mapped index of the narrow and wide configurations.
    for (int g = 1; g < 3; g++) begin
      for (int k = 0; k < ncfg(g); k++) begin
        a = $urandom; a[23:20] = 4'(k);
        txn(g, 1'b0, a, $urandom, 4'hF, k % 4);
      end
    end

    for (int i = 0; i < 200; i++) begin
      int g, r;
      g = $urandom_range(0, 2);
      r = $urandom_range(0, 3);
      a = $urandom;
      if (r < 2)       ix = 4'($urandom_range(0, ncfg(g) - 1));
      else if (r == 2) ix = 4'hF;
      else             ix = 4'($urandom_range(0, 15));
      a[23:20] = ix;
      dl = $urandom_range(0, 3) == 0 ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 6);
      txn(g, 1'($urandom), a, $urandom, 4'($urandom), dl);
    end

    chk("cyc_eq_stb", 32'(cycbad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mpc_wb_router.md
MPC_WB_ROUTER -- requirements
Module: mpc_wb_router

Interface
REQ-001 The block SHALL take parameter N_MACROS, default 4, meaning the number of user-macro Wishbone ports (legal 2..8).
REQ-002 The block SHALL take parameter TIMEOUT, default 255, meaning the cycles a forwarded access waits for a macro ack (legal 2..65535).
REQ-003 The block SHALL take parameter SEL_LSB, default 20, meaning the LSB of the 4-bit target field idx = wbs_adr_i[SEL_LSB+3:SEL_LSB].
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-005 The block SHALL have the host Wishbone slave ports: wbs_stb_i/wbs_cyc_i/wbs_we_i  in  1; wbs_sel_i  in  4; wbs_dat_i/wbs_adr_i  in  32; wbs_ack_o  out  1; wbs_dat_o  out  32.
REQ-006 The block SHALL have the macro-side ports: m_cyc_o/m_stb_o  out  N_MACROS, one bit per macro; m_we_o  out  1; m_sel_o  out  4; m_adr_o/m_dat_o  out  32, shared by all macros; m_ack_i  in  N_MACROS; m_dat_i  in  32*N_MACROS, macro k on bits [32k+31:32k].
REQ-007 The block SHALL have the status ports: configuration  out  4, the pad-mux select; timeout_err  out  1, the sticky timeout flag.

Function
REQ-008 The FSM SHALL have the states IDLE, FWD and ACK, encoded in 2 bits.
REQ-009 In IDLE with wbs_cyc_i & wbs_stb_i, the block SHALL classify idx as local (idx==4'hF), mapped (idx<N_MACROS) or unmapped (all other values).
REQ-010 Local and unmapped requests SHALL go IDLE->ACK, giving wbs_ack_o exactly 1 cycle after the request is sampled.
REQ-011 A mapped request SHALL go IDLE->FWD and register adr, dat, we and sel onto m_*_o.
REQ-012 In FWD, m_cyc_o[idx] and m_stb_o[idx] SHALL be 1 and all other bits SHALL be 0.
REQ-013 In FWD, on m_ack_i[idx] the block SHALL capture m_dat_i slice idx into wbs_dat_o and go to ACK; ack bits of non-selected macros SHALL be ignored.
REQ-014 A 16-bit wait counter SHALL clear on FWD entry and increment each FWD cycle without ack.
REQ-015 When the wait counter reaches TIMEOUT-1 without ack, the block SHALL go to ACK with wbs_dat_o=32'hFFFF_FFFF, set timeout_err and record idx in last_to.
REQ-016 An ack arriving in the same cycle as the timeout SHALL win: normal data, no error.
REQ-017 ACK SHALL drive wbs_ack_o=1 for exactly one cycle and then return to IDLE; wbs_ack_o SHALL be 0 in every other state.
REQ-018 In ACK all m_cyc_o and m_stb_o bits SHALL be 0; m_adr_o, m_dat_o, m_we_o and m_sel_o SHALL hold their last values.
REQ-019 If wbs_cyc_i drops while in FWD, the block SHALL go to IDLE next cycle with no ack and no error flag.
REQ-020 Local register CFG (adr[3:2]=0) SHALL be read/write; bits[3:0] drive configuration and are written only when wbs_sel_i[0]=1.
REQ-021 Local register STATUS (adr[3:2]=1) SHALL read {20'd0, last_to[3:0], 7'd0, timeout_err}; writing 1 to bit0 with wbs_sel_i[0]=1 SHALL clear timeout_err.
REQ-022 If a STATUS clear and a new timeout occur in the same cycle, set SHALL win.
REQ-023 Reads of other local offsets SHALL return 0; writes to other local offsets SHALL be ignored.
REQ-024 Unmapped reads SHALL return 32'hBADA_DD00; unmapped writes SHALL be ignored; neither SHALL raise an error.
REQ-025 configuration SHALL change only on the clock edge that enters ACK for a CFG write.

Reset
REQ-026 While wb_rst_i=1, asynchronously: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, all m_*_o=0, configuration=0, timeout_err=0, last_to=0, wait counter=0.
REQ-027 Reset asserted mid-FWD SHALL drop the macro strobe immediately and produce no ack after release.
REQ-028 After release, the first request SHALL be sampled on the first rising edge with wb_rst_i=0.

Verification
REQ-029 Write 0x0000_0005 to idx=F, CFG -> ack 1 cycle later; configuration=5; a CFG read returns 0x5.
REQ-030 Read idx=2 with macro 2 acking 3 cycles into FWD with 0x1234_5678 -> m_stb_o=0100 during FWD; wbs_ack_o 1 cycle after m_ack_i; wbs_dat_o=0x1234_5678.
REQ-031 TIMEOUT=8, idx=1 never acks -> ack after 8 FWD cycles; data 0xFFFF_FFFF; STATUS reads 0x0000_0101; writing 1 to STATUS bit0 makes it read 0x0000_0100.
REQ-032 N_MACROS=4, read idx=6 -> 1-cycle ack; data 0xBADA_DD00; no m_stb_o activity.
REQ-033 wbs_cyc_i dropped in the 2nd FWD cycle -> m_stb_o=0 next cycle, wbs_ack_o never asserted; wb_rst_i pulsed mid-FWD -> all outputs 0 asynchronously.
REQ-034 Sweep N_MACROS=2 and N_MACROS=8 -> every mapped idx routes to the correct m_stb_o bit and m_dat_i slice.
